// File: rtl/x2821_pkg.sv
// Shared definitions for the ss2 pulse path.
//   state_t   : receiver FSM states ARM / IDLE / MEASURE / STUCK (2 bits)
//   ss2_width : width in bits of a counter able to hold N+TOL+1
package x2821_pkg;

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_MEASURE = 2'd2,
    ST_STUCK   = 2'd3
  } state_t;

  function automatic int unsigned ss2_width(input int unsigned n, input int unsigned tol);
    return $clog2(n + tol + 2);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Parameterised-depth flop chain for bringing an asynchronous line into i_clk.
//   i_clk     : clock, rising edge
//   i_reset_n : asynchronous active-low reset; every stage resets to RST_VAL
//   i_d       : raw input
//   o_q       : synchronised output (DEPTH = 0 gives a plain passthrough)
module sync_ff #(
  parameter int unsigned DEPTH   = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_q = i_d;
    end else begin : g_chain
      logic [DEPTH-1:0] chain;

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          chain <= {DEPTH{RST_VAL}};
        end else begin
          chain[0] <= i_d;
          for (int unsigned i = 1; i < DEPTH; i++) begin
            chain[i] <= chain[i-1];
          end
        end
      end

      assign o_q = chain[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/ss2_rx.sv
// Pulse-width decoder for the ss2 single-shot path. Measures each active
// pulse on i_in in clock cycles and classifies it.
//   i_clk     : clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   i_in      : pulse line, inactive level NE
//   o_valid   : one-cycle strobe, pulse width within N +/- TOL
//   o_short   : one-cycle strobe, pulse narrower than N-TOL
//   o_long    : one-cycle strobe, pulse reached N+TOL+1 while still active
//   o_width   : last measured width, held until the next strobe
//   o_busy    : high whenever the FSM is not in IDLE
module ss2_rx
  import x2821_pkg::*;
#(
  parameter  int unsigned N    = 5,
  parameter  logic        NE   = 1'b0,
  parameter  int unsigned TOL  = 1,
  parameter  int unsigned SYNC = 2,
  localparam int unsigned W    = ss2_width(N, TOL)
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_in,
  output logic         o_valid,
  output logic         o_short,
  output logic         o_long,
  output logic [W-1:0] o_width,
  output logic         o_busy
);

  localparam logic [W-1:0] LO = W'(N - TOL);
  localparam logic [W-1:0] HI = W'(N + TOL);

  logic         s;
  logic         act;
  state_t       state;
  logic [W-1:0] cnt;

  sync_ff #(
    .DEPTH   (SYNC),
    .RST_VAL (NE)
  ) u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_in),
    .o_q       (s)
  );

  assign act    = (s != NE);
  assign o_busy = (state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= ST_ARM;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_short <= 1'b0;
      o_long  <= 1'b0;
      o_width <= '0;
    end else begin
      o_valid <= 1'b0;
      o_short <= 1'b0;
      o_long  <= 1'b0;
      case (state)
        // A line already active when we come out of reset is never measured.
        ST_ARM: begin
          if (!act) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (act) begin
            state <= ST_MEASURE;
            cnt   <= W'(1);
          end
        end
        ST_MEASURE: begin
          if (act) begin
            // cnt < HI is cnt+1 <= N+TOL without needing a wider sum
            if (cnt < HI) begin
              cnt <= cnt + W'(1);
            end else begin
              o_long  <= 1'b1;
              o_width <= HI + W'(1);
              state   <= ST_STUCK;
            end
          end else begin
            if (cnt < LO) o_short <= 1'b1;
            else          o_valid <= 1'b1;
            o_width <= cnt;
            state   <= ST_IDLE;
          end
        end
        ST_STUCK: begin
          if (!act) state <= ST_IDLE;
        end
        default: state <= ST_ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_ss2_rx.sv
// Bench for ss2_rx: two instances (NE=0/SYNC=2 and NE=1/SYNC=0) driven with
// the same logical pulse train, checked every cycle against a run-length model.
module tb_ss2_rx;

  localparam int N      = 5;
  localparam int TOL    = 1;
  localparam int SYNC_A = 2;
  localparam int SYNC_B = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_a, in_b;
  logic       valid_a, short_a, long_a, busy_a;
  logic       valid_b, short_b, long_b, busy_b;
  logic [2:0] width_a, width_b;

  int n_checks = 0;
  int n_errors = 0;

  // model state, index 0 = instance A, 1 = instance B
  int       j_cnt [2];
  bit [7:0] hist  [2];
  bit       pv    [2];
  bit       meas  [2];
  int       run   [2];
  bit       e_valid [2];
  bit       e_short [2];
  bit       e_long  [2];
  bit       e_busy  [2];
  int       e_width [2];

  always #5 clk = ~clk;

  ss2_rx #(.N(N), .NE(1'b0), .TOL(TOL), .SYNC(SYNC_A)) u_dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_in(in_a),
    .o_valid(valid_a), .o_short(short_a), .o_long(long_a),
    .o_width(width_a), .o_busy(busy_a)
  );

  ss2_rx #(.N(N), .NE(1'b1), .TOL(TOL), .SYNC(SYNC_B)) u_dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_in(in_b),
    .o_valid(valid_b), .o_short(short_b), .o_long(long_b),
    .o_width(width_b), .o_busy(busy_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      j_cnt[d] = 0; hist[d] = '0; pv[d] = 0; meas[d] = 0; run[d] = 0;
      e_valid[d] = 0; e_short[d] = 0; e_long[d] = 0;
      e_busy[d] = 1; e_width[d] = 0;
    end
  endtask

  // One clock edge after reset release. A pulse is a run of active samples as
  // seen after the synchronizer; it counts only if an inactive sample was seen
  // after release just before it. Runs reaching N+TOL+1 report long once.
  task automatic model_edge(input int d, input bit a);
    int  sd;
    bit  v;
    sd = (d == 0) ? SYNC_A : SYNC_B;
    j_cnt[d]++;
    hist[d] = {hist[d][6:0], a};
    v = (j_cnt[d] > sd) ? hist[d][sd] : 1'b0;
    e_valid[d] = 0; e_short[d] = 0; e_long[d] = 0;
    if (v) begin
      if (!pv[d]) begin
        run[d]  = 1;
        meas[d] = (j_cnt[d] >= 2);
      end else begin
        run[d]++;
      end
      if (meas[d] && run[d] == N + TOL + 1) begin
        e_long[d]  = 1;
        e_width[d] = N + TOL + 1;
        meas[d]    = 0;
      end
    end else begin
      if (pv[d] && meas[d]) begin
        if (run[d] < N - TOL) e_short[d] = 1;
        else                  e_valid[d] = 1;
        e_width[d] = run[d];
      end
      meas[d] = 0;
    end
    pv[d]     = v;
    e_busy[d] = v;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".A.strobes"}, {29'd0, valid_a, short_a, long_a}, {29'd0, e_valid[0], e_short[0], e_long[0]});
    check_eq({tag, ".A.width"},   {29'd0, width_a}, e_width[0]);
    check_eq({tag, ".A.busy"},    {31'd0, busy_a},  {31'd0, e_busy[0]});
    check_eq({tag, ".B.strobes"}, {29'd0, valid_b, short_b, long_b}, {29'd0, e_valid[1], e_short[1], e_long[1]});
    check_eq({tag, ".B.width"},   {29'd0, width_b}, e_width[1]);
    check_eq({tag, ".B.busy"},    {31'd0, busy_b},  {31'd0, e_busy[1]});
  endtask

  task automatic drive(input bit a);
    in_a = a;
    in_b = ~a;
  endtask

  task automatic cycle(input bit a);
    @(negedge clk);
    drive(a);
    @(posedge clk);
    if (rst_n) begin
      model_edge(0, a);
      model_edge(1, a);
    end
    #1;
    compare_all("cyc");
  endtask

  task automatic level(input bit a, input int n);
    for (int i = 0; i < n; i++) cycle(a);
  endtask

  task automatic pulse(input int w, input int gap);
    level(1'b1, w);
    level(1'b0, gap);
  endtask

  // Async assertion away from any edge; release lands 3 time units after a
  // rising edge so the next edge is the first one counted by the model.
  task automatic pulse_reset(input int hold, input bit a);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    drive(a);
    #1;
    model_reset();
    compare_all("rst");
    level(a, hold);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int w;
    int g;
    rst_n = 1'b0;
    drive(1'b0);
    model_reset();
    #1;
    compare_all("por");
    level(1'b0, 2);
    #2;
    rst_n = 1'b1;

    // directed cases
    level(1'b0, 3);
    pulse(5, 3);
    pulse(4, 3);
    pulse(6, 3);
    pulse(3, 3);
    pulse(1, 3);
    pulse(20, 4);
    pulse(5, 1);
    pulse(5, 3);
    // reset three cycles into a pulse
    level(1'b1, 3);
    pulse_reset(2, 1'b0);
    level(1'b0, 4);
    // line held active across reset release
    level(1'b1, 2);
    pulse_reset(2, 1'b1);
    level(1'b1, 4);
    level(1'b0, 4);
    pulse(5, 3);

    // randomized pulse train
    for (int k = 0; k < 200; k++) begin
      w = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(1, 9));
      g = int'($urandom_range(1, 4));
      if ($urandom_range(0, 29) == 0) begin
        level(1'b1, int'($urandom_range(1, 8)));
        pulse_reset(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        level(1'b0, g);
      end else begin
        pulse(w, g);
      end
    end
    level(1'b0, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
